ring_buffer_reader: RTL and testbench
=====================================

RING_BUFFER_READER -- requirements
Module: ring_buffer_reader

Interface
REQ-001 SHALL have parameter DATA_OF_SET, default 4: elements per buffer entry (set).
REQ-002 SHALL have parameter DATA_WIDTH, default 8: bits per element.
REQ-003 SHALL have parameter CNT_WIDTH, default 8: width of the set counter and num_sets.
REQ-004 SHALL have port clk, input, 1: single clock; all state rises on posedge clk.
REQ-005 SHALL have port rst, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1: one-cycle command pulse.
REQ-007 SHALL have port num_sets, input, CNT_WIDTH: sets to drain, sampled with start.
REQ-008 SHALL have port busy, output, 1: command in progress.
REQ-009 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port buf_empty, input, 1: ring buffer empty_flag.
REQ-011 SHALL have port buf_ren, output, 1: ring buffer read enable.
REQ-012 SHALL have port buf_dout, input, [DATA_OF_SET-1:0][DATA_WIDTH-1:0]: ring buffer read data, valid the cycle after buf_ren=1 with buf_empty=0.
REQ-013 SHALL have port out_valid, output, 1: element stream valid.
REQ-014 SHALL have port out_ready, input, 1: downstream ready.
REQ-015 SHALL have port out_data, output, DATA_WIDTH: current element.
REQ-016 SHALL have port out_last, output, 1: current element is the final element of the final set.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, CAPTURE, SEND, DONE.
REQ-018 IDLE: busy=0; start=1 with num_sets!=0 latches num_sets, clears set counter, goes to FETCH.
REQ-019 IDLE: start=1 with num_sets==0 goes to DONE; no buf_ren is issued.
REQ-020 start while busy=1 SHALL be ignored.
REQ-021 FETCH: buf_ren = !buf_empty, combinational, for exactly one cycle; on buf_empty=0 goes to CAPTURE, else stays in FETCH with buf_ren=0.
REQ-022 CAPTURE: registers buf_dout into the internal set register, clears element index, goes to SEND.
REQ-023 SEND: out_valid=1; out_data = set_reg[idx]; element 0 is sent first.
REQ-024 A transfer occurs when out_valid && out_ready; idx increments by 1 per transfer.
REQ-025 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-026 On transfer of idx==DATA_OF_SET-1: set counter increments; goes to DONE if counter+1==num_sets, else to FETCH.
REQ-027 out_last = out_valid && idx==DATA_OF_SET-1 && set counter==num_sets-1.
REQ-028 DONE: done=1 for one cycle, busy=0, then IDLE.
REQ-029 busy=1 in FETCH, CAPTURE, SEND; 0 in IDLE and DONE.
REQ-030 out_valid SHALL be 0 outside SEND; buf_ren SHALL be 0 outside FETCH.
REQ-031 Minimum latency per set SHALL be DATA_OF_SET+2 cycles (FETCH, CAPTURE, DATA_OF_SET SEND beats) with out_ready=1 and buf_empty=0.
REQ-032 Counter arithmetic SHALL be unsigned CNT_WIDTH; idx width SHALL be clog2(DATA_OF_SET), minimum 1.

Reset
REQ-033 rst=0 SHALL immediately force state IDLE, clear set register, idx and counters, and drive busy, done, buf_ren, out_valid, out_last and out_data to 0.
REQ-034 Reset mid-command SHALL abort without a done pulse; the next start after rst=1 SHALL run normally.

Verification
REQ-035 Reset: rst=0 asynchronously between clock edges -> all outputs 0 before the next clk edge.
REQ-036 Buffer entry {4,3,2,1} (element 0 = 1), start with num_sets=1, out_ready=1 -> buf_ren high 1 cycle; out_data 1,2,3,4 on 4 consecutive cycles; out_last with 4; done the next cycle.
REQ-037 Backpressure: out_ready=0 for 3 cycles while out_data=2 -> out_valid=1 and out_data=2 held; 3 follows the cycle after out_ready=1.
REQ-038 Empty stall: buf_empty=1 for 5 cycles after start -> buf_ren=0, out_valid=0, busy=1; read proceeds the cycle buf_empty=0.
REQ-039 start with num_sets=0 -> done pulse the next cycle; buf_ren never asserted.
REQ-040 num_sets=2 with entries {1,1,1,1} and {2,2,2,2}; rst=0 during the second set's SEND -> outputs 0 and no done; a new start with num_sets=1 completes normally.

Source files
------------

// File: rtl/ring_buffer_reader.sv
// ring_buffer_reader
// Drains a programmable number of sets from a ring buffer. Each set is one
// buffer entry of DATA_OF_SET elements, which is streamed out one element per
// valid/ready handshake, element 0 first.
//
// Ports
//   clk        : single clock, all state on the rising edge
//   rst        : asynchronous active-low reset
//   start      : one-cycle command pulse (ignored while busy)
//   num_sets   : number of sets to drain, sampled with start
//   busy       : command in progress (FETCH, CAPTURE, SEND)
//   done       : one-cycle completion pulse
//   buf_empty  : ring buffer empty flag
//   buf_ren    : ring buffer read enable
//   buf_dout   : ring buffer read data, valid the cycle after an accepted read
//   out_valid  : element stream valid
//   out_ready  : downstream ready
//   out_data   : current element
//   out_last   : current element is the final element of the final set
module ring_buffer_reader #(
   parameter int DATA_OF_SET = 4,
   parameter int DATA_WIDTH  = 8,
   parameter int CNT_WIDTH   = 8
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic [CNT_WIDTH-1:0]                   num_sets,
   output logic                                   busy,
   output logic                                   done,
   input  logic                                   buf_empty,
   output logic                                   buf_ren,
   input  logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] buf_dout,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [DATA_WIDTH-1:0]                  out_data,
   output logic                                   out_last
);

   localparam int IDX_W = (DATA_OF_SET > 1) ? $clog2(DATA_OF_SET) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_OF_SET - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      CAPTURE = 3'd2,
      SEND    = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t                                 state_r;
   state_t                                 state_nxt_s;
   logic [CNT_WIDTH-1:0]                   num_sets_r;
   logic [CNT_WIDTH-1:0]                   set_cnt_r;
   logic [CNT_WIDTH-1:0]                   set_cnt_inc_s;
   logic [IDX_W-1:0]                       idx_r;
   logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] set_reg_r;
   logic                                   load_cmd_s;
   logic                                   capture_s;
   logic                                   xfer_s;
   logic                                   last_elem_s;

   assign set_cnt_inc_s = set_cnt_r + CNT_WIDTH'(1);
   assign last_elem_s   = (idx_r == IDX_LAST);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode and all outputs; outputs are pure decodes of state and
   // registered datapath, except buf_ren which must follow buf_empty directly.
   always_comb begin
      state_nxt_s = state_r;
      busy        = 1'b0;
      done        = 1'b0;
      buf_ren     = 1'b0;
      out_valid   = 1'b0;
      out_data    = {DATA_WIDTH{1'b0}};
      out_last    = 1'b0;
      load_cmd_s  = 1'b0;
      capture_s   = 1'b0;
      xfer_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (num_sets != {CNT_WIDTH{1'b0}}) begin
                  load_cmd_s  = 1'b1;
                  state_nxt_s = FETCH;
               end else begin
                  // Zero-length command completes without touching the buffer.
                  state_nxt_s = DONE;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         FETCH: begin
            busy    = 1'b1;
            buf_ren = !buf_empty;
            if (!buf_empty) begin
               state_nxt_s = CAPTURE;
            end else begin
               state_nxt_s = FETCH;
            end
         end
         CAPTURE: begin
            busy        = 1'b1;
            capture_s   = 1'b1;
            state_nxt_s = SEND;
         end
         SEND: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = set_reg_r[idx_r];
            out_last  = last_elem_s && (set_cnt_r == (num_sets_r - CNT_WIDTH'(1)));
            xfer_s    = out_ready;
            if (out_ready && last_elem_s) begin
               if (set_cnt_inc_s == num_sets_r) begin
                  state_nxt_s = DONE;
               end else begin
                  state_nxt_s = FETCH;
               end
            end else begin
               state_nxt_s = SEND;
            end
         end
         DONE: begin
            done        = 1'b1;
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Command, set counter, element index and captured set register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         num_sets_r <= {CNT_WIDTH{1'b0}};
         set_cnt_r  <= {CNT_WIDTH{1'b0}};
         idx_r      <= {IDX_W{1'b0}};
         set_reg_r  <= {(DATA_OF_SET*DATA_WIDTH){1'b0}};
      end else begin
         if (load_cmd_s) begin
            num_sets_r <= num_sets;
            set_cnt_r  <= {CNT_WIDTH{1'b0}};
         end else if (xfer_s && last_elem_s) begin
            set_cnt_r <= set_cnt_inc_s;
         end
         if (capture_s) begin
            set_reg_r <= buf_dout;
            idx_r     <= {IDX_W{1'b0}};
         end else if (xfer_s) begin
            // Wrap explicitly so a non-power-of-two set never indexes past the end.
            idx_r <= last_elem_s ? {IDX_W{1'b0}} : (idx_r + IDX_W'(1));
         end
      end
   end

endmodule

// File: tb/tb_ring_buffer_reader.sv
// Testbench for ring_buffer_reader: a stimulus process pushes expected
// {out_last, out_data} beats and expected done pulses; independent monitors
// pop and compare whenever the DUT transfers an element or pulses done.
module tb_ring_buffer_reader;

   logic             clk;
   logic             rst;
   logic             start;
   logic [7:0]       num_sets;
   logic             busy;
   logic             done;
   logic             buf_empty;
   logic             buf_ren;
   logic [3:0][7:0]  buf_dout;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_data;
   logic             out_last;

   logic [3:0][7:0]  mem [0:7];
   int               rd_ptr;
   int               ren_count;
   logic [8:0]       exp_q [$];
   int               done_exp;
   int               checks;
   int               errors;

   ring_buffer_reader #(
      .DATA_OF_SET(4),
      .DATA_WIDTH (8),
      .CNT_WIDTH  (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .num_sets (num_sets),
      .busy     (busy),
      .done     (done),
      .buf_empty(buf_empty),
      .buf_ren  (buf_ren),
      .buf_dout (buf_dout),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_last (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Ring buffer model: data appears the cycle after an accepted read.
   always @(posedge clk) begin
      if (buf_ren && !buf_empty) begin
         buf_dout <= mem[rd_ptr];
         rd_ptr    = rd_ptr + 1;
         ren_count = ren_count + 1;
      end
   end

   // Element monitor: compare every transfer against the scoreboard.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL stream_unexpected: got data=%0d last=%0b, required no transfer", out_data, out_last);
         end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            if ({out_last, out_data} !== e) begin
               errors = errors + 1;
               $display("FAIL stream_beat: got data=%0d last=%0b, required data=%0d last=%0b",
                        out_data, out_last, e[7:0], e[8]);
            end
         end
      end
   end

   // Done monitor: every done pulse must have been announced by the stimulus.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         checks = checks + 1;
         if (done_exp == 0) begin
            errors = errors + 1;
            $display("FAIL done_unexpected: got done=1, required done=0");
         end else begin
            done_exp = done_exp - 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks = checks + 1;
      if (act !== req) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic push_set(input logic [3:0][7:0] ent, input bit final_set, input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({(final_set && i == 3), ent[i]});
      end
   endtask

   task automatic pulse_start(input logic [7:0] n);
      @(posedge clk); #1;
      start    = 1'b1;
      num_sets = n;
      @(posedge clk); #1;
      start    = 1'b0;
   endtask

   // Counts falling edges until done, then checks latency and pulse width.
   task automatic wait_done(input int exp_n, input string name);
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 200) begin
         @(negedge clk);
         n = n + 1;
         if (done === 1'b1) seen = 1'b1;
      end
      checks = checks + 1;
      if (!seen) begin
         errors = errors + 1;
         $display("FAIL %s_timeout: got no done in %0d cycles, required done", name, n);
      end else begin
         if (n != exp_n) begin
            errors = errors + 1;
            $display("FAIL %s_latency: got %0d cycles, required %0d", name, n, exp_n);
         end
         @(negedge clk);
         chk({name, "_done_width"}, {30'd0, done, busy}, 32'd0);
      end
   endtask

   initial begin
      int ren0;
      checks    = 0;
      errors    = 0;
      done_exp  = 0;
      rd_ptr    = 0;
      ren_count = 0;
      buf_dout  = '0;
      rst       = 1'b0;
      start     = 1'b0;
      num_sets  = 8'd0;
      buf_empty = 1'b0;
      out_ready = 1'b1;
      mem[0] = {8'd4, 8'd3, 8'd2, 8'd1};
      mem[1] = {8'd4, 8'd3, 8'd2, 8'd1};
      mem[2] = {8'h40, 8'h30, 8'h20, 8'h10};
      mem[3] = {8'd1, 8'd1, 8'd1, 8'd1};
      mem[4] = {8'd2, 8'd2, 8'd2, 8'd2};
      mem[5] = {8'h0d, 8'h0c, 8'h0b, 8'h0a};
      mem[6] = '0;
      mem[7] = '0;

      #3;
      chk("reset_outputs", {19'd0, busy, done, buf_ren, out_valid, out_last, out_data}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Single set, no backpressure.
      push_set(mem[0], 1'b1, 4);
      done_exp = done_exp + 1;
      ren0 = ren_count;
      pulse_start(8'd1);
      wait_done(7, "single");
      chk("single_ren_count", ren_count - ren0, 32'd1);

      // Backpressure while element 2 is presented.
      push_set(mem[1], 1'b1, 4);
      done_exp = done_exp + 1;
      pulse_start(8'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_hold", {22'd0, out_valid, out_last, out_data}, {22'd0, 1'b1, 1'b0, 8'd2});
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      wait_done(4, "bp");

      // Empty stall for five cycles after start.
      push_set(mem[2], 1'b1, 4);
      done_exp  = done_exp + 1;
      buf_empty = 1'b1;
      pulse_start(8'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_state", {29'd0, buf_ren, out_valid, busy}, 32'd1);
         @(posedge clk); #1;
      end
      buf_empty = 1'b0;
      @(negedge clk);
      chk("stall_release_ren", {31'd0, buf_ren}, 32'd1);
      wait_done(6, "stall");

      // Zero-length command.
      done_exp = done_exp + 1;
      ren0 = ren_count;
      pulse_start(8'd0);
      wait_done(1, "zero");
      chk("zero_ren_count", ren_count - ren0, 32'd0);

      // Two sets, reset during the second set's SEND.
      push_set(mem[3], 1'b0, 4);
      push_set(mem[4], 1'b1, 2);
      pulse_start(8'd2);
      repeat (10) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("abort_outputs", {19'd0, busy, done, buf_ren, out_valid, out_last, out_data}, 32'd0);
      chk("abort_beats_drained", exp_q.size(), 32'd0);
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_idle", {30'd0, busy, done}, 32'd0);

      // A fresh command after the abort completes normally.
      push_set(mem[5], 1'b1, 4);
      done_exp = done_exp + 1;
      pulse_start(8'd1);
      wait_done(7, "after_abort");

      chk("final_beats_drained", exp_q.size(), 32'd0);
      chk("final_done_drained", done_exp, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
